// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider, one quotient bit per clock
// Signed operands are reduced to magnitudes up front and the signs reapplied in FIX.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] dend_mag, dvs_mag;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zero_d  = zero_q;
        dz_d    = dz_q;
        done_d  = 1'b0;

        dend_mag = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_mag  = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
        // Borrow out of the (WIDTH+1)-bit subtraction means the trial failed
        trial    = {rem_q, acc_q[WIDTH-1]} - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        // acc carries the raw dividend through to the remainder
                        acc_d   = dividend;
                        zero_d  = 1'b1;
                        state_d = FIX;
                    end else begin
                        acc_d   = dend_mag;
                        dvs_d   = dvs_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
                        qneg_d  = sign && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rneg_d  = sign && dividend[WIDTH-1];
                        zero_d  = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], acc_q[WIDTH-1]} : trial[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d = 1'b1;
                dz_d   = zero_q;
                if (zero_q) begin
                    quo_d = '1;
                    rmd_d = acc_q;
                end else begin
                    quo_d = qneg_q ? -acc_q : acc_q;
                    rmd_d = rneg_q ? -rem_q : rem_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed vector bench for div_unit
// Inputs driven and outputs sampled on the falling edge.
module tb_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sign = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    int n_vec = 0;
    int n_err = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sign(sign),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge following the accepting edge; counts further edges until done.
    task automatic wait_done(input bit hold, input int pulse_at, output int n, output bit busy_ok);
        n = 0;
        busy_ok = busy;
        while (!done && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = hold || (n == pulse_at);
            if (n == pulse_at) begin
                dividend = 32'd7;
                divisor  = 32'd0;
            end
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    task automatic check_result(input string name, input vec_t v, input int n, input bit busy_ok);
        chk({name, ".latency"}, n, v.z ? 1 : 33);
        chk({name, ".busy_during"}, {31'd0, busy_ok}, 1);
        chk({name, ".busy_at_done"}, {31'd0, busy}, 0);
        chk({name, ".quotient"}, quotient, v.q);
        chk({name, ".remainder"}, remainder, v.r);
        chk({name, ".div_zero"}, {31'd0, div_zero}, {31'd0, v.z});
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        bit bok;
        n_vec++;
        sign = v.sgn; dividend = v.a; divisor = v.b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dividend = ~v.a;  // operands must not matter after acceptance
        wait_done(1'b0, -1, n, bok);
        check_result(v.name, v, n, bok);
        @(posedge clk);
        @(negedge clk);
        chk({v.name, ".done_one_cycle"}, {31'd0, done}, 0);
    endtask

    vec_t tbl[12];
    vec_t va, vb;
    int   n;
    bit   bok;
    int   dones;

    initial begin
        tbl[0]  = '{"u12_6",      1'b0, 32'd12,        32'd6,         32'd2,         32'd0,         1'b0};
        tbl[1]  = '{"u_max_16",   1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'hF,         1'b0};
        tbl[2]  = '{"s_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        tbl[3]  = '{"s_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
        tbl[4]  = '{"s_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
        tbl[5]  = '{"u_div0",     1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        tbl[6]  = '{"s_div0",     1'b1, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        tbl[7]  = '{"u100_7",     1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        tbl[8]  = '{"u5_9",       1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
        tbl[9]  = '{"s_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
        tbl[10] = '{"u_big_div",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        tbl[11] = '{"s_mn_1",     1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        chk("reset.busy", {31'd0, busy}, 0);
        chk("reset.done", {31'd0, done}, 0);
        chk("reset.quotient", quotient, 0);
        chk("reset.remainder", remainder, 0);
        chk("reset.div_zero", {31'd0, div_zero}, 0);

        for (int i = 0; i < 12; i++) run_vec(tbl[i]);

        // Start pulsed (with a zero divisor) while busy must not disturb the running divide
        n_vec++;
        va = '{"ignored_start", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0};
        sign = 1'b0; dividend = va.a; divisor = va.b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, 10, n, bok);
        check_result(va.name, va, n, bok);

        // Start held high through done: second operation accepted on the done cycle
        n_vec++;
        va = '{"b2b_first",  1'b0, 32'd50,        32'd4, 32'd12, 32'd2, 1'b0};
        vb = '{"b2b_second", 1'b1, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 1'b0};
        @(negedge clk);
        sign = va.sgn; dividend = va.a; divisor = va.b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wait_done(1'b1, -1, n, bok);
        check_result(va.name, va, n, bok);
        sign = vb.sgn; dividend = vb.a; divisor = vb.b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b.busy_after_accept", {31'd0, busy}, 1);
        chk("b2b.held_quotient", quotient, va.q);
        chk("b2b.held_remainder", remainder, va.r);
        wait_done(1'b0, -1, n, bok);
        check_result(vb.name, vb, n, bok);

        // Reset in the middle of a divide
        n_vec++;
        @(negedge clk);
        sign = 1'b0; dividend = 32'd999; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.busy", {31'd0, busy}, 0);
        chk("midrst.done", {31'd0, done}, 0);
        chk("midrst.quotient", quotient, 0);
        chk("midrst.remainder", remainder, 0);
        chk("midrst.div_zero", {31'd0, div_zero}, 0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) dones++;
        end
        chk("midrst.no_done", dones, 0);
        run_vec(tbl[7]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
